fifo_wr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares the single write port of the 32-bit fifo among NREQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: defaults, state encoding, stats width.
package fifo_arb_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int STAT_W        = 16;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        OWN  = ST_OWN
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/fifo side bundle of the write arbiter; master = producers + fifo, slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dataIn;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       grant;
    logic                  FULL;
    logic                  fifo_wr;
    logic [WIDTH-1:0]      fifo_dataIn;

    modport master (
        output req, dataIn, FULL,
        input  ack, grant, fifo_wr, fifo_dataIn
    );

    modport slave (
        input  req, dataIn, FULL,
        output ack, grant, fifo_wr, fifo_dataIn
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic first-set picker: one-hot of the first req at or after rr_ptr, wrapping at NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         pick,
    output logic                    any
);
    localparam int PW = $clog2(NREQ);

    logic          found;
    int            pos;
    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = PW'(pos);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        any = found;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the fifo write port. Optional per-requester beat
// counters on output stat_beats when FIFO_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner; grant the first pending req at/after rr_ptr
// OWN   | grant holds one owner; beats flow while en & ~FULL
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NREQ      = DEF_NREQ,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_beats
`endif
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN) + 1;

    arb_state_t       state;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    rr_ptr;
    logic [CW-1:0]    beat_cnt;

    logic [PW-1:0]    owner;
    logic [PW-1:0]    owner_nxt;
    logic [NREQ-1:0]  ack;
    logic             beat_acc;
    logic             last_beat;
    logic             release_own;
    logic [NREQ-1:0]  pick_req;
    logic [PW-1:0]    pick_ptr;
    logic [NREQ-1:0]  pick;
    logic             pick_any;
    logic [WIDTH-1:0] owner_data;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) owner = PW'(i);
        end
    end

    assign owner_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    assign ack       = (en && state == OWN && !bus.FULL) ? (grant & bus.req) : '0;
    assign beat_acc  = |ack;
    assign last_beat = beat_acc && (beat_cnt == CW'(BURST_LEN - 1));

    // Owner gives up on a full burst or when it stops requesting; frozen while en is low.
    assign release_own = en && (state == OWN) && (last_beat || ((grant & bus.req) == '0));

    // On release the old owner is masked out so it cannot win its own re-pick.
    assign pick_req = (state == OWN) ? (bus.req & ~grant) : bus.req;
    assign pick_ptr = (state == OWN) ? owner_nxt : rr_ptr;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (pick_req),
        .rr_ptr (pick_ptr),
        .pick   (pick),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick;
                        state    <= OWN;
                        beat_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        rr_ptr   <= owner_nxt;
                        beat_cnt <= '0;
                        if (pick_any) begin
                            grant <= pick;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end else if (beat_acc) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) owner_data = bus.dataIn[i*WIDTH +: WIDTH];
        end
    end

    assign bus.ack         = ack;
    assign bus.grant       = grant;
    assign bus.fifo_wr     = beat_acc;
    assign bus.fifo_dataIn = owner_data;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_cnt[i] <= '0;
            end else if (ack[i] && (stat_cnt[i] != {STAT_W{1'b1}})) begin
                stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
            end
        end
        assign stat_beats[i*STAT_W +: STAT_W] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, rotation, FULL stall, owner drop, freeze, reset,
// and per-requester beat counts when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [N*STAT_W-1:0] stat_beats;
`endif

    fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [31:0] v);
        bus.dataIn[i*W +: W] = v;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                              input logic wr, input logic [31:0] d);
        #1;
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".ack"}, 32'(bus.ack), 32'(a));
        chk({tag, ".wr"}, 32'(bus.fifo_wr), 32'(wr));
        chk({tag, ".data"}, bus.fifo_dataIn, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        bus.req    = '0;
        bus.dataIn = '0;
        bus.FULL   = 1'b0;

        // held in reset: requests and enable must not produce grant or ack
        #90;
        en      = 1'b1;
        bus.req = '1;
        put(0, 32'hAA);
        expect_out("rst", 4'b0000, 4'b0000, 1'b0, 32'h0);
        bus.req = '0;
        en      = 1'b0;
        #9;
        rst = 1'b0;
        tick();

        // single requester, 4-beat burst
        en      = 1'b1;
        bus.req = 4'b0001;
        put(0, 32'd1);
        expect_out("s1.pre", 4'b0000, 4'b0000, 1'b0, 32'h0);
        tick();
        for (int b = 1; b <= 4; b++) begin
            put(0, 32'(b));
            expect_out($sformatf("s1.beat%0d", b), 4'b0001, 4'b0001, 1'b1, 32'(b));
            tick();
        end
        bus.req = '0;
        expect_out("s1.end", 4'b0000, 4'b0000, 1'b0, 32'h0);

        // all requesting: rotation with no bubbles, two full rounds
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) put(i, 32'h10 + 32'(i));
        tick();
        for (int g = 0; g < 8; g++) begin
            oh = 4'(1 << (g % 4));
            for (int b = 0; b < 4; b++) begin
                expect_out($sformatf("s2.g%0d.b%0d", g, b), oh, oh, 1'b1, 32'h10 + 32'(g % 4));
                tick();
            end
        end
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("s6.stat%0d", i), 32'(stat_beats[i*STAT_W +: STAT_W]), 32'd8);
`endif
        expect_out("s2.wrap", 4'b0001, 4'b0001, 1'b1, 32'h10);
        bus.req = '0;
        expect_out("s2.drop", 4'b0001, 4'b0000, 1'b0, 32'h10);
        tick();
        expect_out("s2.idle", 4'b0000, 4'b0000, 1'b0, 32'h0);

        // FULL stall after beat 2
        bus.req = 4'b0001;
        put(0, 32'h31);
        tick();
        expect_out("s3.b1", 4'b0001, 4'b0001, 1'b1, 32'h31);
        tick();
        put(0, 32'h32);
        expect_out("s3.b2", 4'b0001, 4'b0001, 1'b1, 32'h32);
        tick();
        bus.FULL = 1'b1;
        put(0, 32'h33);
        for (int c = 0; c < 3; c++) begin
            expect_out($sformatf("s3.full%0d", c), 4'b0001, 4'b0000, 1'b0, 32'h33);
            tick();
        end
        bus.FULL = 1'b0;
        expect_out("s3.b3", 4'b0001, 4'b0001, 1'b1, 32'h33);
        tick();
        put(0, 32'h34);
        expect_out("s3.b4", 4'b0001, 4'b0001, 1'b1, 32'h34);
        tick();
        bus.req = '0;
        expect_out("s3.end", 4'b0000, 4'b0000, 1'b0, 32'h0);

        // owner drops after one beat while req[2] waits
        bus.req = 4'b0001;
        put(0, 32'h41);
        tick();
        bus.req = 4'b0101;
        put(2, 32'h42);
        expect_out("s4.b1", 4'b0001, 4'b0001, 1'b1, 32'h41);
        tick();
        bus.req = 4'b0100;
        expect_out("s4.drop", 4'b0001, 4'b0000, 1'b0, 32'h41);
        tick();
        expect_out("s4.switch", 4'b0100, 4'b0100, 1'b1, 32'h42);
        bus.req = '0;
        expect_out("s4.rel", 4'b0100, 4'b0000, 1'b0, 32'h42);
        tick();
        expect_out("s4.idle", 4'b0000, 4'b0000, 1'b0, 32'h0);

        // rr_ptr is 3 now: req 0011 scans 3,0 and picks 0; then freeze mid-burst
        bus.req = 4'b0011;
        put(0, 32'h51);
        put(1, 32'h61);
        tick();
        expect_out("s5.b1", 4'b0001, 4'b0001, 1'b1, 32'h51);
        tick();
        put(0, 32'h52);
        expect_out("s5.b2", 4'b0001, 4'b0001, 1'b1, 32'h52);
        tick();
        en = 1'b0;
        put(0, 32'h53);
        for (int c = 0; c < 2; c++) begin
            expect_out($sformatf("s5.frz%0d", c), 4'b0001, 4'b0000, 1'b0, 32'h53);
            tick();
        end
        en = 1'b1;
        expect_out("s5.b3", 4'b0001, 4'b0001, 1'b1, 32'h53);
        tick();
        put(0, 32'h54);
        expect_out("s5.b4", 4'b0001, 4'b0001, 1'b1, 32'h54);
        tick();
        expect_out("s5.next", 4'b0010, 4'b0010, 1'b1, 32'h61);
        tick();
        rst = 1'b1;
        expect_out("s5.rst", 4'b0000, 4'b0000, 1'b0, 32'h0);
        bus.req = 4'b0110;
        put(2, 32'h62);
        rst = 1'b0;
        tick();
        expect_out("s5.ptr0", 4'b0010, 4'b0010, 1'b1, 32'h61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
